ram32x3_access_arbiter: RTL and testbench

//  Shares one 32x3 dual-port M10K RAM (separate write/read address ports) between two requesters.

---
 rtl/ram32x3_arb_pkg.sv | 20 ++
 rtl/ram32x3_access_arbiter_rr_pick2.sv | 13 +
 rtl/ram32x3_access_arbiter.sv | 129 ++++++++++++
 tb/tb_ram32x3_access_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ram32x3_arb_pkg.sv
// ram32x3_arb_pkg: shared widths, FSM state encoding and request record for the RAM arbiter
package ram32x3_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 3;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        WR_GAP  = 2'd1,
        RD_WAIT = 2'd2,
        CLEAR   = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/ram32x3_access_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker; ptr is the index granted last, the other side wins a tie
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win,
    output logic       ptr_next
);

    assign win[0]   = req[0] & (~req[1] | ptr);
    assign win[1]   = req[1] & (~req[0] | ~ptr);
    assign ptr_next = win[1] | (ptr & ~win[0]);

endmodule

// File: rtl/ram32x3_access_arbiter.sv
// ram32x3_access_arbiter: serializes two requesters onto one 32x3 RAM; RAM32X3_CLEAR_ON_RESET_EN adds a zeroing sweep after reset
module ram32x3_access_arbiter
    import ram32x3_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_rdaddress,
    input  logic [DATA_W-1:0] ram_q
);

    arb_state_t        state, state_n;
    logic [1:0]        win;
    logic              ptr, ptr_n;
    logic [1:0]        cnt;
    logic              rd_sel;
    logic              grant, rd_done;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
`ifdef RAM32X3_CLEAR_ON_RESET_EN
    logic [ADDR_W-1:0] clr_addr;
    localparam arb_state_t RST_STATE = CLEAR;
`else
    localparam arb_state_t RST_STATE = ARB;
`endif

    rr_pick2 u_pick (
        .req      ({req1, req0}),
        .ptr      (ptr),
        .win      (win),
        .ptr_next (ptr_n)
    );

    assign grant     = (state == ARB) && (|win);
    assign rd_done   = (state == RD_WAIT) && (cnt == 2'(RD_LAT));
    assign sel_we    = win[1] ? we1 : we0;
    assign sel_addr  = win[1] ? addr1 : addr0;
    assign sel_wdata = win[1] ? wdata1 : wdata0;

    // next state: a grant opens a write gap or a read wait, both fall back to ARB
    always_comb begin
        state_n = ARB;
        if (state == ARB)
            state_n = grant ? (sel_we ? WR_GAP : RD_WAIT) : ARB;
        else if (state == RD_WAIT)
            state_n = rd_done ? ARB : RD_WAIT;
`ifdef RAM32X3_CLEAR_ON_RESET_EN
        else if (state == CLEAR)
            state_n = (clr_addr == '1) ? ARB : CLEAR;
`endif
    end

    // registered outputs, RAM port drive and arbitration bookkeeping
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state         <= RST_STATE;
            ptr           <= 1'b1;
            cnt           <= '0;
            rd_sel        <= 1'b0;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            rvalid0       <= 1'b0;
            rvalid1       <= 1'b0;
            rdata0        <= '0;
            rdata1        <= '0;
            busy          <= 1'b0;
            ram_wren      <= 1'b0;
            ram_wraddress <= '0;
            ram_data      <= '0;
            ram_rdaddress <= '0;
`ifdef RAM32X3_CLEAR_ON_RESET_EN
            clr_addr      <= '0;
`endif
        end else begin
            state    <= state_n;
            gnt0     <= grant && win[0];
            gnt1     <= grant && win[1];
            busy     <= (state_n != ARB) || (state == CLEAR);
            ram_wren <= (grant && sel_we) || (state == CLEAR);
            rvalid0  <= rd_done && !rd_sel;
            rvalid1  <= rd_done && rd_sel;
            cnt      <= (state == RD_WAIT) ? cnt + 2'd1 : '0;
            if (rd_done && !rd_sel)
                rdata0 <= ram_q;
            if (rd_done && rd_sel)
                rdata1 <= ram_q;
            if (grant) begin
                ptr    <= ptr_n;
                rd_sel <= win[1];
            end
            if (grant && sel_we) begin
                ram_wraddress <= sel_addr;
                ram_data      <= sel_wdata;
            end
            if (grant && !sel_we)
                ram_rdaddress <= sel_addr;
`ifdef RAM32X3_CLEAR_ON_RESET_EN
            if (state == CLEAR) begin
                ram_wraddress <= clr_addr;
                ram_data      <= '0;
                clr_addr      <= clr_addr + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ram32x3_access_arbiter.sv
// tb_ram32x3_access_arbiter: directed checks of grants, RAM port drive, read latency and reset abort
module tb_ram32x3_access_arbiter;
    import ram32x3_arb_pkg::*;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [4:0] addr0 = '0, addr1 = '0;
    logic [2:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren;
    logic [2:0] rdata0, rdata1, ram_data, ram_q;
    logic [4:0] ram_wraddress, ram_rdaddress;
    logic [2:0] mem [32] = '{default: 3'd0};
    int         n_chk = 0, n_pass = 0;

    ram32x3_access_arbiter dut (
        .CLOCK_50      (clk),
        .Reset         (Reset),
        .req0          (req0),
        .req1          (req1),
        .we0           (we0),
        .we1           (we1),
        .addr0         (addr0),
        .addr1         (addr1),
        .wdata0        (wdata0),
        .wdata1        (wdata1),
        .gnt0          (gnt0),
        .gnt1          (gnt1),
        .rvalid0       (rvalid0),
        .rvalid1       (rvalid1),
        .rdata0        (rdata0),
        .rdata1        (rdata1),
        .busy          (busy),
        .ram_wren      (ram_wren),
        .ram_wraddress (ram_wraddress),
        .ram_data      (ram_data),
        .ram_rdaddress (ram_rdaddress),
        .ram_q         (ram_q)
    );

    always #5 clk = ~clk;

    // behavioural dual-port RAM with one clock of read latency
    always @(posedge clk) begin
        if (ram_wren)
            mem[ram_wraddress] <= ram_data;
        ram_q <= mem[ram_rdaddress];
    end

    function automatic logic [31:0] outs();
        return {7'd0, gnt1, gnt0, rvalid1, rvalid0, rdata1, rdata0, busy, ram_wren,
                ram_wraddress, ram_data, ram_rdaddress};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input int idx, input logic r, input logic w, input logic [4:0] a,
                         input logic [2:0] d);
        ram_req_t t;
        t.we    = w;
        t.addr  = a;
        t.wdata = d;
        if (idx == 0) begin
            req0 = r; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata;
        end else begin
            req1 = r; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata;
        end
    endtask

    task automatic wait_gnt(input int idx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = (idx == 0) ? gnt0 : gnt1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive(0, 1'b0, 1'b0, 5'd0, 3'd0);
        drive(1, 1'b0, 1'b0, 5'd0, 3'd0);
        repeat (3) @(negedge clk);
        Reset = 1'b0;
`ifdef RAM32X3_CLEAR_ON_RESET_EN
        repeat (34) @(negedge clk);
`endif
    endtask

    task automatic do_write(input int idx, input logic [4:0] a, input logic [2:0] d);
        bit ok;
        drive(idx, 1'b1, 1'b1, a, d);
        wait_gnt(idx, ok);
        check("wr_gnt", 32'(ok), 32'd1);
        check("wr_port", {busy, gnt1, gnt0, ram_wren, ram_wraddress, ram_data},
              {1'b1, idx == 1, idx == 0, 1'b1, a, d});
        drive(idx, 1'b0, 1'b0, a, d);
        @(negedge clk);
        check("wr_gap", {gnt1, gnt0, ram_wren}, 3'b000);
    endtask

    task automatic do_read(input int idx, input logic [4:0] a, input logic [2:0] exp);
        bit ok;
        drive(idx, 1'b1, 1'b0, a, 3'd0);
        wait_gnt(idx, ok);
        check("rd_gnt", 32'(ok), 32'd1);
        check("rd_port", {ram_wren, ram_rdaddress}, {1'b0, a});
        drive(idx, 1'b0, 1'b0, a, 3'd0);
        @(negedge clk);
        check("rd_wait", {ram_wren, rvalid1, rvalid0}, 3'b000);
        @(negedge clk);
        check("rd_valid", {rvalid1, rvalid0}, (idx == 1) ? 2'b10 : 2'b01);
        check("rd_data", (idx == 1) ? rdata1 : rdata0, exp);
    endtask

    initial begin
        logic [1:0] pat [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        bit         ok;
        bit         seen_rv;
        int         bad;

        // reset state and first idle cycle
        repeat (3) @(negedge clk);
        check("in_reset", outs(), 32'd0);
        Reset = 1'b0;
`ifdef RAM32X3_CLEAR_ON_RESET_EN
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if ({busy, ram_wren, ram_wraddress, ram_data} !== {1'b1, 1'b1, 5'(i), 3'd0})
                bad++;
        end
        check("clr_sweep", 32'(bad), 32'd0);
        @(negedge clk);
        check("clr_done", {busy, ram_wren}, 2'b00);
`else
        @(negedge clk);
        check("after_reset", outs(), 32'd0);
`endif

        // write then read back through requester 0
        do_write(0, 5'd5, 3'd3);
        do_read(0, 5'd5, 3'd3);

        // address extremes 0 and 31 kept distinct
        do_write(0, 5'd0, 3'd2);
        do_write(1, 5'd31, 3'd5);
        do_read(0, 5'd0, 3'd2);
        do_read(1, 5'd31, 3'd5);

        // two held writers alternate, one grant per two clocks
        do_reset();
        drive(0, 1'b1, 1'b1, 5'd1, 3'd1);
        drive(1, 1'b1, 1'b1, 5'd2, 3'd2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("alt_%0d", i), {gnt1, gnt0, ram_wren}, {pat[i], |pat[i]});
        end
        drive(0, 1'b0, 1'b0, 5'd0, 3'd0);
        drive(1, 1'b0, 1'b0, 5'd0, 3'd0);

        // simultaneous write0 / read1 at address 31: write goes first, read sees it
        do_reset();
        drive(0, 1'b1, 1'b1, 5'd31, 3'd6);
        drive(1, 1'b1, 1'b0, 5'd31, 3'd0);
        @(negedge clk);
        check("race_g0", {gnt1, gnt0, ram_wren, ram_wraddress, ram_data}, {2'b01, 1'b1, 5'd31, 3'd6});
        drive(0, 1'b0, 1'b0, 5'd0, 3'd0);
        @(negedge clk);
        check("race_gap", {gnt1, gnt0}, 2'b00);
        @(negedge clk);
        check("race_g1", {gnt1, gnt0, ram_wren, ram_rdaddress}, {2'b10, 1'b0, 5'd31});
        drive(1, 1'b0, 1'b0, 5'd0, 3'd0);
        @(negedge clk);
        check("race_wait", {rvalid1, rvalid0}, 2'b00);
        @(negedge clk);
        check("race_rv", {rvalid1, rvalid0, rdata1, rdata0}, {2'b10, 3'd6, 3'd0});

        // reset during a read wait drops the read and re-favours requester 0
        do_reset();
        drive(0, 1'b1, 1'b0, 5'd2, 3'd0);
        wait_gnt(0, ok);
        check("abort_gnt", 32'(ok), 32'd1);
        drive(0, 1'b0, 1'b0, 5'd0, 3'd0);
        Reset = 1'b1;
        @(negedge clk);
        check("abort_outs", outs(), 32'd0);
        Reset = 1'b0;
        drive(0, 1'b1, 1'b1, 5'd3, 3'd1);
        drive(1, 1'b1, 1'b1, 5'd4, 3'd4);
        seen_rv = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            seen_rv |= rvalid0 | rvalid1;
            ok = gnt0 | gnt1;
        end
        check("abort_no_rv", 32'(seen_rv), 32'd0);
        check("abort_next", {gnt1, gnt0}, 2'b01);
        drive(0, 1'b0, 1'b0, 5'd0, 3'd0);
        drive(1, 1'b0, 1'b0, 5'd0, 3'd0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
